pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the RISC-V core's fetch stage. Holds the architectural fetch PC, selects the next PC by fixed priority (trap, branch redirect, stall, predicted-taken, sequential), and predicts taken branches with a small direct-mapped branch target buffer (BTB) trained from the execute stage. Feeds the instruction memory address and the fetch/decode pipeline register.

## Interface
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'hBFC00000: PC value loaded by reset.
- BTB_ENTRIES, 16: BTB depth; power of two, 2..256.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (hazard unit).
- redirect  in  1  resolved control-flow correction from EX.
- redirect_PC  in  XLEN  correct next PC when redirect=1.
- trap  in  1  exception/interrupt entry.
- trap_vector  in  XLEN  handler address when trap=1.
- upd_valid  in  1  BTB training strobe from EX (one resolved branch/jump).
- upd_PC  in  XLEN  PC of the resolved instruction.
- upd_target  in  XLEN  its taken target.
- upd_taken  in  1  resolved direction.
- PC_out  out  XLEN  current fetch PC.
- incPC  out  XLEN  PC_out + 4 (combinational, link value).
- pred_taken  out  1  BTB predicts PC_out taken (combinational).
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0.

## Operation
- Next-PC priority: trap -> trap_vector; else redirect -> redirect_PC; else stall -> PC_out; else pred_taken -> pred_target; else incPC.
- Bits [1:0] of trap_vector, redirect_PC, upd_target forced to 0; PC_out[1:0] always 0.
- incPC = PC_out + 4, modulo 2^XLEN (wraps FFFF_FFFC -> 0000_0000). No offset added to the next PC.
- BTB: IDX = log2(BTB_ENTRIES); index = PC[IDX+1:2]; tag = PC[XLEN-1:IDX+2]. Entry = valid, tag, target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup on PC_out: pred_taken = valid & tag match & counter[1].
- Update on upd_valid (independent of stall/redirect/trap):
  - hit: counter +1 sat at 11 if taken, -1 sat at 00 if not; target overwritten if taken.
  - miss and taken: allocate/replace: valid=1, tag, target, counter=10.
  - miss and not taken: no change.

## Timing
- Reset (async assert): PC_out=RESET_VECTOR, all BTB valid/counters/targets=0, so pred_taken=0, pred_target=0, incPC=RESET_VECTOR+4. First edge after deassert applies normal next-PC select.
- PC_out changes one cycle after the selecting inputs; redirect/trap take effect at the next edge (zero bubble inside this block).
- BTB update written at the edge of upd_valid; visible to lookup from the next cycle. Same-cycle lookup and update of the same index returns pre-update contents.
- Simultaneous: trap beats redirect beats stall beats prediction. Stall never blocks training.
- Reset mid-operation: immediate return to reset values regardless of pending redirect/update.

## Structure
- Package pc_pkg: counter state constants (SNT/WNT/WT/ST), INSTR_BYTES=4, btb_entry_t struct parametrisation helpers (index/tag width functions).
- Sub-module btb: storage array, lookup port, training port; pc_unit holds PC register and next-PC mux.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> PC_out=BFC00000 immediately, incPC=BFC00004, pred_taken=0; after release PC steps BFC00004, BFC00008.
- Priority: trap=1 (vector 80000180), redirect=1 (BFC00100), stall=1 same cycle -> next PC 80000180; redirect+stall only -> BFC00100; stall only -> PC held.
- Training: upd_valid, upd_PC=BFC00010, target BFC00040, taken -> next time PC_out=BFC00010, pred_taken=1 and next PC BFC00040; two not-taken updates -> prediction off (10->01).
- Saturation/alias: three taken updates then one not-taken -> still predicts taken (11->10); update with PC BFC00050 (same index, BTB_ENTRIES=16, different tag) replaces entry, BFC00010 misses.
- Same-cycle: update and lookup same index at PC_out -> pred_taken reflects old entry this cycle, new one next visit.
- Wrap/alignment: redirect_PC=FFFFFFFE -> PC_out=FFFFFFFC, next sequential PC 00000000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and sizing helpers for the fetch-stage PC unit and its branch target buffer.
package pc_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  // 2-bit saturating branch direction counter; the upper bit is the prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int unsigned btb_idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned btb_tag_w(input int unsigned xlen, input int unsigned entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer: one combinational lookup port, one training port from EX.
module btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int unsigned IdxW = btb_idx_w(ENTRIES);
  localparam int unsigned TagW = btb_tag_w(XLEN, ENTRIES);

  typedef struct packed {
    logic            valid;
    logic [TagW-1:0] tag;
    logic [XLEN-1:0] target;
    ctr_e            ctr;
  } btb_entry_t;

  btb_entry_t      entries_q [ENTRIES];
  btb_entry_t      lk_entry;
  btb_entry_t      up_entry;
  btb_entry_t      up_entry_d;
  logic [IdxW-1:0] lk_idx;
  logic [IdxW-1:0] up_idx;
  logic [TagW-1:0] lk_tag;
  logic [TagW-1:0] up_tag;
  logic            up_hit;
  logic            up_we;

  assign lk_idx   = lookup_pc[IdxW+1:2];
  assign lk_tag   = lookup_pc[XLEN-1:IdxW+2];
  assign up_idx   = upd_pc[IdxW+1:2];
  assign up_tag   = upd_pc[XLEN-1:IdxW+2];
  assign lk_entry = entries_q[lk_idx];
  assign up_entry = entries_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  always_comb begin
    pred_taken  = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
    pred_target = pred_taken ? lk_entry.target : '0;
  end

  always_comb begin
    up_we      = 1'b0;
    up_entry_d = up_entry;
    if (upd_valid) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (upd_taken) begin
          up_entry_d.ctr    = (up_entry.ctr == ST) ? ST : ctr_e'(up_entry.ctr + 2'd1);
          up_entry_d.target = {upd_target[XLEN-1:2], 2'b00};
        end else begin
          up_entry_d.ctr = (up_entry.ctr == SNT) ? SNT : ctr_e'(up_entry.ctr - 2'd1);
        end
      end else if (upd_taken) begin
        // Miss on a taken branch replaces whatever aliased into this slot.
        up_we             = 1'b1;
        up_entry_d.valid  = 1'b1;
        up_entry_d.tag    = up_tag;
        up_entry_d.target = {upd_target[XLEN-1:2], 2'b00};
        up_entry_d.ctr    = WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (up_we) begin
      entries_q[up_idx] <= up_entry_d;
    end
  end

  logic unused_lsbs;
  assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: PC register, fixed-priority next-PC select and BTB prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned     BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_PC,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_PC,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] incPC,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  assign PC_out = pc_q;
  assign incPC  = pc_q + XLEN'(INSTR_BYTES);

  btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_PC),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken)
  );

  always_comb begin
    pc_d = incPC;
    if (trap) begin
      pc_d = {trap_vector[XLEN-1:2], 2'b00};
    end else if (redirect) begin
      pc_d = {redirect_PC[XLEN-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= {RESET_VECTOR[XLEN-1:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

  logic unused_lsbs;
  assign unused_lsbs = ^{trap_vector[1:0], redirect_PC[1:0]};

endmodule
